// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: M-op encodings,
// FSM state encoding and datapath width.
package alu_defs;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [4:0] ALU_MUL    = {2'b01, F3_MUL};
   localparam logic [4:0] ALU_MULH   = {2'b01, F3_MULH};
   localparam logic [4:0] ALU_MULHSU = {2'b01, F3_MULHSU};
   localparam logic [4:0] ALU_MULHU  = {2'b01, F3_MULHU};
   localparam logic [4:0] ALU_DIV    = {2'b01, F3_DIV};
   localparam logic [4:0] ALU_DIVU   = {2'b01, F3_DIVU};
   localparam logic [4:0] ALU_REM    = {2'b01, F3_REM};
   localparam logic [4:0] ALU_REMU   = {2'b01, F3_REMU};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } mdu_state_e;

   // Takes only ALU_OP[4:3]; the low bits are funct3 and do not affect the class.
   function automatic logic is_mop(input logic [1:0] op_hi);
      return op_hi == 2'b01;
   endfunction

endpackage

// File: rtl/ex_muldiv_unit_sign_fix.sv
// Conditional two's-complement negate followed by a 32-bit word select.
// Used both to take operand magnitudes and to correct final results.
module muldiv_sign_fix #(
   parameter int W = 32
) (
   input  logic [W-1:0] val_i,
   input  logic         neg_i,
   input  logic         hi_sel_i,
   output logic [31:0]  word_o
);

   logic [W-1:0] fixed;

   assign fixed  = neg_i ? (~val_i + {{(W-1){1'b0}}, 1'b1}) : val_i;
   assign word_o = hi_sel_i ? fixed[W-1 -: 32] : fixed[31:0];

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step
// per clock, stalling the pipeline until the result is held in DONE.
module ex_muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic [4:0]      ALU_OP,
   input  logic [XLEN-1:0] DATA1,
   input  logic [XLEN-1:0] DATA2,
   input  logic            STALL_IN,
   output logic [XLEN-1:0] RESULT,
   output logic            BUSYWAIT,
   output logic            DONE
);
   import alu_defs::*;

   mdu_state_e        state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [2:0]        op_q, op_d;
   logic              neg_q, neg_d;
   logic [31:0]       a_q, a_d, b_q, b_d;
   logic [63:0]       acc_q, acc_d;
   logic [31:0]       quo_q, quo_d;
   logic [32:0]       rem_q, rem_d;
   logic [31:0]       result_q, result_d;
   logic              busy;

   logic [2:0]  f3;
   logic        mop, a_signed, b_signed, a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic [63:0] acc_next;
   logic [33:0] r_shift, diff;
   logic [32:0] rem_next;
   logic [31:0] quo_next, prod_word, quo_word, rem_word;

   assign f3       = ALU_OP[2:0];
   assign mop      = is_mop(ALU_OP[4:3]);
   assign a_signed = (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
   assign b_signed = (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   assign a_neg    = a_signed & DATA1[31];
   assign b_neg    = b_signed & DATA2[31];

   muldiv_sign_fix #(.W(32)) u_fix_a (.val_i(DATA1), .neg_i(a_neg), .hi_sel_i(1'b0), .word_o(a_mag));
   muldiv_sign_fix #(.W(32)) u_fix_b (.val_i(DATA2), .neg_i(b_neg), .hi_sel_i(1'b0), .word_o(b_mag));

   assign acc_next = acc_q + (b_q[count_q[4:0]] ? ({32'd0, a_q} << count_q[4:0]) : 64'd0);

   // Restoring step: a borrow out of the 34-bit subtract means the trial failed.
   assign r_shift  = {rem_q, quo_q[31]};
   assign diff     = r_shift - {2'b00, b_q};
   assign rem_next = diff[33] ? r_shift[32:0] : diff[32:0];
   assign quo_next = {quo_q[30:0], ~diff[33]};

   muldiv_sign_fix #(.W(64)) u_fix_prod (.val_i(acc_next), .neg_i(neg_q),
                                         .hi_sel_i(op_q != F3_MUL), .word_o(prod_word));
   muldiv_sign_fix #(.W(32)) u_fix_quo  (.val_i(quo_next), .neg_i(neg_q),
                                         .hi_sel_i(1'b0), .word_o(quo_word));
   muldiv_sign_fix #(.W(32)) u_fix_rem  (.val_i(rem_next[31:0]), .neg_i(neg_q),
                                         .hi_sel_i(1'b0), .word_o(rem_word));

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      op_d     = op_q;
      neg_d    = neg_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      result_d = result_q;
      busy     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mop) begin
               busy    = 1'b1;
               count_d = '0;
               op_d    = f3;
               a_d     = a_mag;
               b_d     = b_mag;
               acc_d   = 64'd0;
               quo_d   = a_mag;
               rem_d   = 33'd0;
               // Remainder follows the dividend; everything else follows the sign product.
               neg_d   = (f3[2] & f3[1]) ? a_neg : (a_neg ^ b_neg);
               state_d = ST_CALC;
               if (f3[2] && (DATA2 == 32'd0)) begin
                  result_d = f3[1] ? DATA1 : 32'hFFFF_FFFF;
                  state_d  = ST_DONE;
               end else if (((f3 == F3_DIV) || (f3 == F3_REM)) &&
                            (DATA1 == 32'h8000_0000) && (DATA2 == 32'hFFFF_FFFF)) begin
                  result_d = f3[1] ? 32'd0 : 32'h8000_0000;
                  state_d  = ST_DONE;
               end
            end
         end
         ST_CALC: begin
            busy    = 1'b1;
            acc_d   = acc_next;
            quo_d   = quo_next;
            rem_d   = rem_next;
            count_d = count_q + 1'b1;
            if (count_q == CNT_W'(31)) begin
               result_d = op_q[2] ? (op_q[1] ? rem_word : quo_word) : prod_word;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!STALL_IN) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         op_q     <= 3'd0;
         neg_q    <= 1'b0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         acc_q    <= 64'd0;
         quo_q    <= 32'd0;
         rem_q    <= 33'd0;
         result_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         result_q <= result_d;
      end
   end

   assign BUSYWAIT = busy & ~RESET;
   assign DONE     = (state_q == ST_DONE);
   assign RESULT   = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: latency, results, special cases,
// DONE hold under STALL_IN and asynchronous reset mid-computation.
module tb_ex_muldiv_unit;
   import alu_defs::*;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [4:0]  ALU_OP;
   logic [31:0] DATA1, DATA2;
   logic        STALL_IN;
   logic [31:0] RESULT;
   logic        BUSYWAIT, DONE;

   int tests_run    = 0;
   int tests_failed = 0;

   ex_muldiv_unit dut (
      .CLK(CLK), .RESET(RESET), .ALU_OP(ALU_OP), .DATA1(DATA1), .DATA2(DATA2),
      .STALL_IN(STALL_IN), .RESULT(RESULT), .BUSYWAIT(BUSYWAIT), .DONE(DONE)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Drives an op at a falling edge and counts the cycles BUSYWAIT stays high.
   // Operands are disturbed once the unit is computing to show they are latched.
   task automatic start_op(input logic [4:0] op, input logic [31:0] d1, input logic [31:0] d2,
                           output int n);
      @(negedge CLK);
      ALU_OP = op; DATA1 = d1; DATA2 = d2;
      #1;
      n = 0;
      while (BUSYWAIT && n < 100) begin
         n++;
         if (n == 2) begin
            DATA1 = ~d1;
            DATA2 = d2 ^ 32'h0000_0005;
         end
         @(negedge CLK);
         #1;
      end
   endtask

   task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] exp, input int exp_busy);
      int n;
      start_op(op, d1, d2, n);
      check_eq({tag, "_busy"}, n, exp_busy);
      check_eq({tag, "_done"}, {31'd0, DONE}, 32'd1);
      check_eq({tag, "_result"}, RESULT, exp);
      ALU_OP = 5'b00000;
      @(negedge CLK);
      #1;
      check_eq({tag, "_exit"}, {30'd0, DONE, BUSYWAIT}, 32'd0);
   endtask

   initial begin
      int n;
      RESET = 1'b1; ALU_OP = ALU_MUL; DATA1 = 32'd3; DATA2 = 32'd4; STALL_IN = 1'b0;
      repeat (2) @(negedge CLK);
      #1;
      check_eq("reset_busy", {31'd0, BUSYWAIT}, 32'd0);
      check_eq("reset_done", {31'd0, DONE}, 32'd0);
      check_eq("reset_result", RESULT, 32'd0);
      ALU_OP = 5'b00000;
      @(negedge CLK);
      RESET = 1'b0;

      run_op("mul",    ALU_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
      run_op("mulh",   ALU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
      run_op("mulhu",  ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run_op("mulhsu", ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
      run_op("div",    ALU_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
      run_op("rem",    ALU_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
      run_op("divu",   ALU_DIVU,   32'd100,       32'd7,         32'd14,        33);
      run_op("remu",   ALU_REMU,   32'd100,       32'd7,         32'd2,         33);
      run_op("div0",   ALU_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1);
      run_op("rem0",   ALU_REM,    32'd5,         32'd0,         32'd5,         1);
      run_op("divovf", ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("removf", ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
      run_op("mulhneg", ALU_MULH,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 33);

      // Non-M ops leave the unit idle and the last result untouched.
      ALU_OP = 5'b00000; DATA1 = 32'd9; DATA2 = 32'd0;
      repeat (2) begin
         @(negedge CLK);
         #1;
         check_eq("nonm_idle", {30'd0, DONE, BUSYWAIT}, 32'd0);
         check_eq("nonm_hold", RESULT, 32'hFFFF_FFFF);
         ALU_OP = 5'b11100;
      end

      // Held instruction stays in DONE while the pipeline is frozen elsewhere.
      start_op(ALU_MUL, 32'd3, 32'd5, n);
      check_eq("stall_busy", n, 33);
      STALL_IN = 1'b1;
      repeat (5) begin
         @(negedge CLK);
         #1;
         check_eq("stall_done", {31'd0, DONE}, 32'd1);
         check_eq("stall_nobusy", {31'd0, BUSYWAIT}, 32'd0);
         check_eq("stall_result", RESULT, 32'd15);
      end
      STALL_IN = 1'b0;
      ALU_OP = 5'b00000;
      @(negedge CLK);
      #1;
      check_eq("stall_exit", {31'd0, DONE}, 32'd0);

      // Reset arrives between clock edges after ten CALC iterations.
      @(negedge CLK);
      ALU_OP = ALU_DIVU; DATA1 = 32'd100; DATA2 = 32'd7;
      repeat (11) @(negedge CLK);
      #1;
      check_eq("pre_reset_busy", {31'd0, BUSYWAIT}, 32'd1);
      #2;
      RESET = 1'b1;
      #1;
      check_eq("arst_busy", {31'd0, BUSYWAIT}, 32'd0);
      check_eq("arst_done", {31'd0, DONE}, 32'd0);
      check_eq("arst_result", RESULT, 32'd0);
      ALU_OP = 5'b00000;
      @(negedge CLK);
      RESET = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         #1;
         check_eq("post_reset_idle", {30'd0, DONE, BUSYWAIT}, 32'd0);
      end
      run_op("post_reset_divu", ALU_DIVU, 32'd100, 32'd7, 32'd14, 33);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
